alarm_set_ctrl: RTL and testbench
=================================

ALARM_SET_CTRL -- requirements
Module: alarm_set_ctrl

Interface
REQ-001 SHALL have parameter RING_SECS, default 60, meaning number of 1 Hz ticks the alarm rings before auto-stop.
REQ-002 SHALL have port Clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port Clear  input  1  synchronous, active-low reset.
REQ-004 SHALL have port Tick  input  1  one-cycle 1 Hz time-base pulse.
REQ-005 SHALL have port Btn_mode  input  1  one-cycle pulse; advances mode.
REQ-006 SHALL have port Btn_inc  input  1  one-cycle pulse; increments the field selected by mode.
REQ-007 SHALL have port Alarm_en  input  1  level; 1 = alarm armed.
REQ-008 SHALL have port Mode  output  3  current state encoding.
REQ-009 SHALL have ports Hours (5), Minutes (6), Seconds (6)  output  current time, binary.
REQ-010 SHALL have ports Alm_hours (5), Alm_minutes (6)  output  alarm time, binary.
REQ-011 SHALL have port Ring  output  1  level; alarm sounding.

Function
REQ-012 SHALL implement states RUN=0, SET_HR=1, SET_MIN=2, ALM_HR=3, ALM_MIN=4; Mode equals the state; all outputs registered.
REQ-013 SHALL move on Btn_mode RUN->SET_HR->SET_MIN->ALM_HR->ALM_MIN->RUN, one step per pulse, visible on Mode the cycle after the pulse.
REQ-014 SHALL, when Btn_mode and Btn_inc are high in the same cycle, take the mode step and discard the increment.
REQ-015 SHALL, in RUN, ALM_HR, ALM_MIN, advance Seconds on Tick; 59->0 carries into Minutes; 59->0 carries into Hours; 23->0 wraps; 23:59:59 -> 00:00:00 in one cycle.
REQ-016 SHALL, in SET_HR and SET_MIN, ignore Tick (time frozen).
REQ-017 SHALL, in SET_HR, on Btn_inc set Hours to (Hours+1) mod 24, no carry elsewhere.
REQ-018 SHALL, in SET_MIN, on Btn_inc set Minutes to (Minutes+1) mod 60 and Seconds to 0, no carry into Hours.
REQ-019 SHALL, in ALM_HR / ALM_MIN, on Btn_inc increment Alm_hours mod 24 / Alm_minutes mod 60.
REQ-020 SHALL ignore Btn_inc in RUN except as ring stop (REQ-023).
REQ-021 SHALL set Ring on the cycle after a Tick whose resulting time equals Alm_hours:Alm_minutes:00, when Alarm_en=1 and state is not SET_HR/SET_MIN.
REQ-022 SHALL count Ticks while Ring=1 and clear Ring on the cycle after the RING_SECS-th Tick.
REQ-023 SHALL clear Ring the cycle after any Btn_mode or Btn_inc pulse, or immediately when Alarm_en=0; a stop pulse also performs its normal mode/increment action.
REQ-024 SHALL, if a new match occurs while Ring=1, keep Ring high and restart the ring count.
REQ-025 SHALL never produce Hours>23, Minutes>59, Seconds>59, Alm_hours>23 or Alm_minutes>59.

Reset
REQ-026 SHALL, on Clock edge with Clear=0, set state RUN, time 00:00:00, alarm 06:00, Ring=0, ring count 0; Clear overrides all other inputs.
REQ-027 SHALL restore reset values when Clear is asserted in any state, including mid-ring and mid-set.

Structure
REQ-028 SHALL take state encodings, MAX_HR=23, MAX_MIN=59, MAX_SEC=59 and reset alarm values from shared package alarm_pkg.
REQ-029 SHALL instantiate sub-module mod_counter (parameter MODULUS; inputs Clock, Clear, Inc; outputs Value, Wrap) for seconds, minutes, hours and both alarm fields.

Verification
REQ-030 SHALL cover rollover: load 23:59:59 via set mode, return to RUN, one Tick -> 00:00:00, Ring=0.
REQ-031 SHALL cover mode cycle: 5 Btn_mode pulses -> Mode 1,2,3,4,0; simultaneous Btn_mode+Btn_inc in SET_HR -> Mode=2, Hours unchanged.
REQ-032 SHALL cover frozen set: in SET_MIN with time 10:20:35, 5 Ticks then one Btn_inc -> 10:21:00.
REQ-033 SHALL cover alarm: alarm 06:01, time 06:00:59, Alarm_en=1, one Tick -> Ring=1 next cycle; 60 further Ticks -> Ring=0.
REQ-034 SHALL cover stop: while ringing, Btn_inc in RUN -> Ring=0, time unchanged; Alarm_en=0 -> Ring=0.
REQ-035 SHALL cover reset: Clear=0 for one cycle during ringing in ALM_MIN -> Mode=0, 00:00:00, alarm 06:00, Ring=0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared constants and types for the alarm clock time-setting controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_pkg;

    // Field widths of the time and alarm outputs
    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    // Largest legal value of each field
    localparam int MAX_HR  = 23;
    localparam int MAX_MIN = 59;
    localparam int MAX_SEC = 59;

    // Alarm time loaded by reset (06:00)
    localparam int ALM_HR_RST  = 6;
    localparam int ALM_MIN_RST = 0;

    // Mode encoding; the Mode output carries these values directly
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_ALM_HR  = 3'd3,
        ST_ALM_MIN = 3'd4
    } state_e;

    // One step around the mode ring; unknown encodings fall back to RUN
    function automatic state_e next_mode(input state_e cur);
        case (cur)
            ST_RUN:     next_mode = ST_SET_HR;
            ST_SET_HR:  next_mode = ST_SET_MIN;
            ST_SET_MIN: next_mode = ST_ALM_HR;
            ST_ALM_HR:  next_mode = ST_ALM_MIN;
            default:    next_mode = ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MODULUS up-counter with a loadable reset value and a carry-out.
// Latency: Value updates one cycle after Inc; Wrap is combinational with Inc.
// Backpressure: none; every Inc pulse is taken.
module mod_counter #(
    parameter int MODULUS   = 60,
    parameter int WIDTH     = 6,
    parameter int RESET_VAL = 0
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Inc,
    output logic [WIDTH-1:0] Value,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             at_last;

    // Anything at or above the last legal value rolls to zero, so the
    // counter can never leave its legal range
    assign at_last = (value_q >= LAST);

    // Next value: hold, or step with wrap to zero
    always_comb begin
        value_d = value_q;
        if (Inc) begin
            value_d = at_last ? '0 : value_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low clear
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            value_q <= RSTV;
        end else begin
            value_q <= value_d;
        end
    end

    assign Value = value_q;
    assign Wrap  = Inc && at_last;

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm clock: running time, button-driven set modes, alarm match and ring timer.
// Latency: every output is registered and reflects inputs one cycle later.
// Backpressure: none; Tick and button pulses are consumed in the cycle they arrive.
module alarm_set_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS = 60
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Tick,
    input  logic             Btn_mode,
    input  logic             Btn_inc,
    input  logic             Alarm_en,
    output logic [2:0]       Mode,
    output logic [HR_W-1:0]  Hours,
    output logic [MIN_W-1:0] Minutes,
    output logic [SEC_W-1:0] Seconds,
    output logic [HR_W-1:0]  Alm_hours,
    output logic [MIN_W-1:0] Alm_minutes,
    output logic             Ring
);

    localparam int RC_W = $clog2(RING_SECS + 1);
    localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SECS);

    state_e state_q;
    state_e state_d;

    logic            ring_q;
    logic            ring_d;
    logic [RC_W-1:0] ring_cnt_q;
    logic [RC_W-1:0] ring_cnt_d;
    logic [RC_W-1:0] ring_cnt_inc;

    logic inc_eff;
    logic run_mode;
    logic in_set_hr;
    logic in_set_min;
    logic in_alm_hr;
    logic in_alm_min;
    logic stop_pulse;

    logic sec_inc;
    logic min_inc;
    logic hr_inc;
    logic alm_hr_inc;
    logic alm_min_inc;
    logic sec_zero;
    logic sec_clear_n;

    logic sec_wrap;
    logic min_wrap;
    logic hr_wrap;
    logic unused_alm_hr_wrap;
    logic unused_alm_min_wrap;

    logic [MIN_W-1:0] min_next;
    logic [HR_W-1:0]  hr_next;
    logic             match;

    // Mode register
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode advances one step per Btn_mode pulse
    always_comb begin
        state_d = state_q;
        if (Btn_mode) begin
            state_d = next_mode(state_q);
        end
    end

    assign Mode = state_q;

    // A mode press in the same cycle swallows the increment
    assign inc_eff    = Btn_inc && !Btn_mode;
    assign in_set_hr  = (state_q == ST_SET_HR);
    assign in_set_min = (state_q == ST_SET_MIN);
    assign in_alm_hr  = (state_q == ST_ALM_HR);
    assign in_alm_min = (state_q == ST_ALM_MIN);
    assign run_mode   = !in_set_hr && !in_set_min;
    assign stop_pulse = Btn_mode || Btn_inc;

    // Time advances on Tick only outside the set modes. Carries from the
    // set-mode increments are never fed forward, so setting minutes cannot
    // disturb hours.
    assign sec_inc     = run_mode && Tick;
    assign min_inc     = (run_mode && Tick && sec_wrap) || (in_set_min && inc_eff);
    assign hr_inc      = (run_mode && Tick && min_wrap) || (in_set_hr && inc_eff);
    assign alm_hr_inc  = in_alm_hr && inc_eff;
    assign alm_min_inc = in_alm_min && inc_eff;

    // Setting minutes restarts the second count from zero; done by pulsing
    // the seconds counter's clear
    assign sec_zero    = in_set_min && inc_eff;
    assign sec_clear_n = Clear && !sec_zero;

    mod_counter #(.MODULUS(MAX_SEC + 1), .WIDTH(SEC_W), .RESET_VAL(0)) u_sec (
        .Clock (Clock),
        .Clear (sec_clear_n),
        .Inc   (sec_inc),
        .Value (Seconds),
        .Wrap  (sec_wrap)
    );

    mod_counter #(.MODULUS(MAX_MIN + 1), .WIDTH(MIN_W), .RESET_VAL(0)) u_min (
        .Clock (Clock),
        .Clear (Clear),
        .Inc   (min_inc),
        .Value (Minutes),
        .Wrap  (min_wrap)
    );

    mod_counter #(.MODULUS(MAX_HR + 1), .WIDTH(HR_W), .RESET_VAL(0)) u_hr (
        .Clock (Clock),
        .Clear (Clear),
        .Inc   (hr_inc),
        .Value (Hours),
        .Wrap  (hr_wrap)
    );

    mod_counter #(.MODULUS(MAX_HR + 1), .WIDTH(HR_W), .RESET_VAL(ALM_HR_RST)) u_alm_hr (
        .Clock (Clock),
        .Clear (Clear),
        .Inc   (alm_hr_inc),
        .Value (Alm_hours),
        .Wrap  (unused_alm_hr_wrap)
    );

    mod_counter #(.MODULUS(MAX_MIN + 1), .WIDTH(MIN_W), .RESET_VAL(ALM_MIN_RST)) u_alm_min (
        .Clock (Clock),
        .Clear (Clear),
        .Inc   (alm_min_inc),
        .Value (Alm_minutes),
        .Wrap  (unused_alm_min_wrap)
    );

    // Time the current Tick is about to produce; only meaningful when the
    // seconds are wrapping, which is the only case that can land on hh:mm:00
    always_comb begin
        min_next = min_wrap ? '0 : Minutes + 1'b1;
        hr_next  = Hours;
        if (min_wrap) begin
            hr_next = hr_wrap ? '0 : Hours + 1'b1;
        end
    end

    assign match = run_mode && Tick && Alarm_en && sec_wrap &&
                   (min_next == Alm_minutes) && (hr_next == Alm_hours);

    assign ring_cnt_inc = ring_cnt_q + 1'b1;

    // Ring control: disarm or a button press stops it, a match (re)starts
    // the count, otherwise count ticks until the ring period expires.
    // Dropping Alarm_en silences the bell on the very next edge.
    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (!Alarm_en || stop_pulse) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
        end else if (match) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
        end else if (ring_q && Tick) begin
            if (ring_cnt_inc == RING_LAST) begin
                ring_d     = 1'b0;
                ring_cnt_d = '0;
            end else begin
                ring_cnt_d = ring_cnt_inc;
            end
        end
    end

    // Ring state registers
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign Ring = ring_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl with hand-computed expectations.
// Latency: checks sample 1 time unit after the rising edge that applied a step.
// Backpressure: n/a.
module tb_alarm_set_ctrl;

    logic       Clock;
    logic       Clear;
    logic       Tick;
    logic       Btn_mode;
    logic       Btn_inc;
    logic       Alarm_en;
    logic [2:0] Mode;
    logic [4:0] Hours;
    logic [5:0] Minutes;
    logic [5:0] Seconds;
    logic [4:0] Alm_hours;
    logic [5:0] Alm_minutes;
    logic       Ring;

    int checks = 0;
    int errors = 0;

    alarm_set_ctrl #(.RING_SECS(60)) dut (
        .Clock       (Clock),
        .Clear       (Clear),
        .Tick        (Tick),
        .Btn_mode    (Btn_mode),
        .Btn_inc     (Btn_inc),
        .Alarm_en    (Alarm_en),
        .Mode        (Mode),
        .Hours       (Hours),
        .Minutes     (Minutes),
        .Seconds     (Seconds),
        .Alm_hours   (Alm_hours),
        .Alm_minutes (Alm_minutes),
        .Ring        (Ring)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".hours"},   32'(Hours),   32'(h));
        chk({tag, ".minutes"}, 32'(Minutes), 32'(m));
        chk({tag, ".seconds"}, 32'(Seconds), 32'(s));
    endtask

    // One clock with the given pulses, then inputs return low
    task automatic step(input logic t, input logic m, input logic i);
        Tick     = t;
        Btn_mode = m;
        Btn_inc  = i;
        @(posedge Clock);
        #1;
        Tick     = 1'b0;
        Btn_mode = 1'b0;
        Btn_inc  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic modes(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        Clear = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        Clear = 1'b1;
    endtask

    initial begin
        Clear    = 1'b0;
        Tick     = 1'b0;
        Btn_mode = 1'b0;
        Btn_inc  = 1'b0;
        Alarm_en = 1'b0;
        @(posedge Clock);
        #1;
        do_reset();

        // Reset state
        chk("rst.mode", 32'(Mode), 0);
        chk_time("rst", 0, 0, 0);
        chk("rst.alm_hours", 32'(Alm_hours), 6);
        chk("rst.alm_minutes", 32'(Alm_minutes), 0);
        chk("rst.ring", 32'(Ring), 0);

        // Mode ring 1,2,3,4,0
        for (int k = 1; k <= 5; k++) begin
            modes(1);
            chk($sformatf("cycle.mode%0d", k), 32'(Mode), 32'(k % 5));
        end

        // Simultaneous mode + inc in SET_HR: step taken, increment dropped
        modes(1);
        step(1'b0, 1'b1, 1'b1);
        chk("simul.mode", 32'(Mode), 2);
        chk("simul.hours", 32'(Hours), 0);

        // Btn_inc ignored in RUN
        modes(3);
        chk("run.mode", 32'(Mode), 0);
        incs(2);
        chk_time("run.inc_ignored", 0, 0, 0);

        // Load 23:59 through the set modes, checking hour/minute wrap
        modes(1);
        incs(23);
        chk("sethr.hours23", 32'(Hours), 23);
        incs(1);
        chk("sethr.wrap", 32'(Hours), 0);
        incs(23);
        ticks(3);
        chk_time("sethr.frozen", 23, 0, 0);
        modes(1);
        incs(59);
        chk("setmin.min59", 32'(Minutes), 59);
        incs(1);
        chk_time("setmin.wrap_no_carry", 23, 0, 0);
        incs(59);
        modes(3);
        chk("roll.mode", 32'(Mode), 0);
        Alarm_en = 1'b1;
        ticks(59);
        chk_time("roll.pre", 23, 59, 59);
        ticks(1);
        chk_time("roll.post", 0, 0, 0);
        chk("roll.ring", 32'(Ring), 0);
        Alarm_en = 1'b0;

        // Frozen set: 10:20:35 in SET_MIN, 5 ticks, one inc -> 10:21:00
        modes(1);
        incs(10);
        modes(1);
        incs(20);
        modes(3);
        ticks(35);
        chk_time("frz.run", 10, 20, 35);
        modes(2);
        chk("frz.mode", 32'(Mode), 2);
        ticks(5);
        chk_time("frz.held", 10, 20, 35);
        incs(1);
        chk_time("frz.inc", 10, 21, 0);

        // Alarm 06:01, time 06:00:59, ring for 60 ticks
        do_reset();
        modes(1);
        incs(6);
        modes(3);
        incs(1);
        chk("alm.mode", 32'(Mode), 4);
        chk("alm.alm_minutes", 32'(Alm_minutes), 1);
        chk("alm.alm_hours", 32'(Alm_hours), 6);
        modes(1);
        Alarm_en = 1'b1;
        ticks(59);
        chk_time("alm.pre", 6, 0, 59);
        chk("alm.ring_pre", 32'(Ring), 0);
        ticks(1);
        chk("alm.ring_on", 32'(Ring), 1);
        ticks(59);
        chk("alm.ring_59", 32'(Ring), 1);
        ticks(1);
        chk("alm.ring_off", 32'(Ring), 0);
        chk_time("alm.after", 6, 2, 0);

        // Stop by Btn_inc in RUN: alarm 06:03
        modes(4);
        incs(2);
        modes(1);
        chk("stop.mode", 32'(Mode), 0);
        ticks(60);
        chk("stop.ring_on", 32'(Ring), 1);
        incs(1);
        chk("stop.ring_inc", 32'(Ring), 0);
        chk_time("stop.time", 6, 3, 0);

        // Stop by Alarm_en=0: alarm 06:04
        modes(4);
        incs(1);
        modes(1);
        ticks(60);
        chk("dis.ring_on", 32'(Ring), 1);
        Alarm_en = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("dis.ring_off", 32'(Ring), 0);

        // Reset while ringing in ALM_MIN: alarm 06:05
        Alarm_en = 1'b1;
        modes(4);
        incs(1);
        ticks(60);
        chk("clr.mode_pre", 32'(Mode), 4);
        chk_time("clr.pre", 6, 5, 0);
        chk("clr.ring_pre", 32'(Ring), 1);
        Clear = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        Clear = 1'b1;
        chk("clr.mode", 32'(Mode), 0);
        chk_time("clr", 0, 0, 0);
        chk("clr.alm_hours", 32'(Alm_hours), 6);
        chk("clr.alm_minutes", 32'(Alm_minutes), 0);
        chk("clr.ring", 32'(Ring), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
